// File: rtl/round_ctrl.sv
// Round/stage sequencer: launches NUM_STAGES chained transform stages per round
// for NUM_ROUNDS rounds, with per-stage timeout, abort and sticky fault.
module round_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_ROUNDS = 24,
    parameter int TIMEOUT    = 1023,
    localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [7:0]            round_idx,
    output logic [SW-1:0]         stage_idx
);

    // state  | meaning
    // IDLE   | waiting for start, indices hold last values
    // LAUNCH | one-cycle start pulse to the current stage
    // WAIT   | waiting for the current stage's ready, counting toward timeout
    // FAULT  | stage timed out; sticky until the next start
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FAULT} state_t;

    state_t                state_q, state_d;
    logic [7:0]            round_q, round_d;
    logic [SW-1:0]         stage_q, stage_d;
    logic [15:0]           wait_q, wait_d;
    logic [NUM_STAGES-1:0] start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic                  finish;
    logic                  ready_sel;
    logic                  last_stage;
    logic                  last_round;

    assign ready_sel  = stage_ready[stage_q];
    assign last_stage = (stage_q == SW'(NUM_STAGES - 1));
    assign last_round = (round_q == 8'(NUM_ROUNDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            stage_q <= '0;
            wait_q  <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            stage_q <= stage_d;
            wait_q  <= wait_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        stage_d = stage_q;
        wait_d  = wait_q;
        finish  = 1'b0;
        case (state_q)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    state_d = S_LAUNCH;
                    round_d = '0;
                    stage_d = '0;
                    wait_d  = '0;
                end
            end
            S_LAUNCH: begin
                wait_d = '0;
                if (abort) state_d = S_IDLE;
                else       state_d = S_WAIT;
            end
            S_WAIT: begin
                // abort beats ready, ready beats timeout
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ready_sel) begin
                    if (!last_stage) begin
                        stage_d = stage_q + SW'(1);
                        state_d = S_LAUNCH;
                    end else if (!last_round) begin
                        stage_d = '0;
                        round_d = round_q + 8'd1;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_IDLE;
                        finish  = 1'b1;
                    end
                end else if (wait_q == 16'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        start_d = '0;
        if (state_d == S_LAUNCH) start_d = NUM_STAGES'(1) << stage_d;
        busy_d  = (state_d == S_LAUNCH) || (state_d == S_WAIT);
        done_d  = finish;
        fault_d = (state_d == S_FAULT);
    end

    assign stage_start = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign round_idx   = round_q;
    assign stage_idx   = stage_q;

endmodule
